mem_access_ctrl: RTL
====================

# mem_access_ctrl

Memory-stage access sequencer. It sits on the consuming side of the EX/MEM pipeline latch. It takes the latched memory-operation fields (read/write enables, atomic flag, address, store data, halt) and issues a held request to the data cache. It stalls the pipeline until the cache answers `dhit`, then returns load or SC-result data to the MEM/WB path.

## Interface
- `ADDR_W`, 32, width of `addr_in` / `dmemaddr`
- `DATA_W`, 32, width of store/load data
- `CNT_W`, 16, width of `access_cnt`

- `CLK`  in  1  clock, rising edge
- `nRST`  in  1  asynchronous reset, active low
- `dREN_in`  in  1  EX/MEM latched load request
- `dWEN_in`  in  1  EX/MEM latched store request
- `datomic_in`  in  1  EX/MEM latched atomic flag (LL with dREN, SC with dWEN)
- `halt_in`  in  1  EX/MEM latched halt
- `addr_in`  in  ADDR_W  EX/MEM latched ALU result (byte address)
- `store_in`  in  DATA_W  EX/MEM latched rdat2 (store data)
- `dhit`  in  1  cache completion strobe
- `dmemload`  in  DATA_W  cache read data; SC result (1 = success, 0 = fail) for SC
- `dmemREN`  out  1  cache read request
- `dmemWEN`  out  1  cache write request
- `datomic`  out  1  cache atomic qualifier
- `dmemaddr`  out  ADDR_W  cache address
- `dmemstore`  out  DATA_W  cache store data
- `stall`  out  1  hold EX/MEM and earlier stages (drives latch enable low)
- `load_data`  out  DATA_W  captured `dmemload`
- `load_valid`  out  1  `load_data` valid for MEM/WB this cycle
- `misalign_err`  out  1  one-cycle pulse, misaligned access dropped
- `halted`  out  1  sticky halt flag
- `access_cnt`  out  CNT_W  completed cache accesses

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- `req = (dREN_in | dWEN_in) & ~halted`.
- IDLE:
  - If `req` and `addr_in[1:0] == 0`:
    - latch `addr_in`, `store_in`, and `datomic_in`
    - latch WEN = `dWEN_in`, and REN = `dREN_in & ~dWEN_in` (write wins if both are set)
    - go to BUSY
  - If `req` and `addr_in[1:0] != 0`: pulse `misalign_err`, issue no request, stay in IDLE.
  - If `halt_in` and no `req`: set `halted`.
- BUSY:
  - `dmemREN`, `dmemWEN`, `datomic`, `dmemaddr`, `dmemstore` are driven from the latched registers and held stable until `dhit`.
  - On `dhit`: capture `dmemload` into `load_data`, increment `access_cnt` (wraps at 2^CNT_W), go to DONE.
- DONE:
  - All `dmem*` enables are 0 and `stall` = 0, so the EX/MEM latch advances at this edge.
  - `load_valid` = 1 if the latched op was a load or an SC; a plain store gives 0.
  - Go to IDLE unconditionally. The new EX/MEM contents are evaluated in the following cycle.
- `stall` is combinational: `stall = (IDLE & req & aligned) | BUSY`. It is 0 in DONE.
- `dhit` outside BUSY is ignored: no capture, no count.
- `halted` is sticky until `nRST`. Once set, `req` is masked and no new requests issue. An access already in BUSY completes normally.
- `dmemaddr` and `dmemstore` hold their last values when idle. The enables are the only qualifiers.

## Timing
- Reset values:
  - FSM = IDLE
  - `dmemREN`, `dmemWEN`, `datomic` = 0
  - `dmemaddr`, `dmemstore` = 0
  - `load_data` = 0, `load_valid` = 0
  - `misalign_err` = 0, `halted` = 0, `access_cnt` = 0
- `stall` is 0 under reset.
- Reset mid-BUSY drops the cache request asynchronously, the same instant `nRST` falls.
- Minimum latency with `dhit` in the first BUSY cycle:
  - cycle 0: IDLE, `stall` = 1
  - cycle 1: BUSY, enables high, `dhit` sampled
  - cycle 2: DONE, `load_valid` = 1, `stall` = 0
- Total latency is 2 + (cycles until `dhit`).
- Cache handshake: request enables and address/data stay constant from BUSY entry through the `dhit` cycle. They deassert in the cycle after `dhit`.
- `misalign_err` is high for exactly one cycle per misaligned presentation. Because `stall` stays 0, the instruction leaves EX/MEM on the next edge.

## Test plan
- Load, `addr_in` = 0x0000_0040, `dhit` 3 cycles after BUSY entry with `dmemload` = 0xDEAD_BEEF:
  - `dmemREN` high for 3 cycles, `stall` high for 4
  - `load_data` = 0xDEAD_BEEF with `load_valid` in DONE
  - `access_cnt` = 1
- Store, `addr_in` = 0x100, `store_in` = 0x1234_5678, `dhit` in the first BUSY cycle:
  - `dmemWEN` high for 1 cycle with `dmemaddr` = 0x100 and `dmemstore` = 0x1234_5678
  - `load_valid` stays 0
- SC (`dWEN_in`, `datomic_in`), `dmemload` = 1 at `dhit`:
  - `datomic` = 1 throughout BUSY
  - `load_data` = 1, `load_valid` = 1
- Both enables set, `addr_in` = 0x8: `dmemWEN` = 1 and `dmemREN` = 0.
- Misaligned load at 0x42: no `dmem*` enable, `misalign_err` high for 1 cycle, `stall` = 0, `access_cnt` unchanged.
- Halt and reset:
  - `halt_in` with no request sets `halted`; a later load at 0x40 issues nothing.
  - Separately, `nRST` low in mid-BUSY clears `dmemREN` immediately and returns to IDLE with all outputs at reset values.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer: turns latched EX/MEM memory fields into a held
// data-cache request, stalls until dhit, and hands load/SC results to MEM/WB.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic              datomic_in,
    input  logic              halt_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] store_in,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic              datomic,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              misalign_err,
    output logic              halted,
    output logic [CNT_W-1:0]  access_cnt
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q, state_d;
    logic               ren_q, wen_q, atomic_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  store_q;
    logic [DATA_W-1:0]  load_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               halted_q;

    logic req, aligned, is_idle, is_busy, is_done, accept;

    assign req     = (dREN_in | dWEN_in) & ~halted_q;
    assign aligned = (addr_in[1:0] == 2'b00);
    assign is_idle = (state_q == StIdle);
    assign is_busy = (state_q == StBusy);
    assign is_done = (state_q == StDone);
    assign accept  = is_idle & req & aligned;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StBusy;
            StBusy: if (dhit) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= StIdle;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            atomic_q <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            load_q   <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= addr_in;
                store_q  <= store_in;
                atomic_q <= datomic_in;
                wen_q    <= dWEN_in;
                ren_q    <= dREN_in & ~dWEN_in;
            end
            if (is_busy && dhit) begin
                load_q <= dmemload;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (is_idle && halt_in && !req) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Enables qualify the request; address/data registers simply hold when idle.
    assign dmemREN   = is_busy & ren_q;
    assign dmemWEN   = is_busy & wen_q;
    assign datomic   = is_busy & atomic_q;
    assign dmemaddr  = addr_q;
    assign dmemstore = store_q;

    // Gated by nRST so a request presented during reset cannot stall or flag.
    assign stall        = nRST & (accept | is_busy);
    assign misalign_err = nRST & is_idle & req & ~aligned;

    // SC returns its success flag through the load path, plain stores do not.
    assign load_valid = is_done & (ren_q | (wen_q & atomic_q));
    assign load_data  = load_q;
    assign halted     = halted_q;
    assign access_cnt = cnt_q;

endmodule
